// File: rtl/stage_id_pipe_pkg.sv
// Shared types and helpers for the MIPS decode stage (stage_id_pipe).
// Enumerations mirror the encodings of the pc_src, br_mode, ext_op and mem_to_reg_wb control fields.
package stage_id_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2,
    PC_JR  = 2'd3
  } pc_src_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LEZ = 3'd2,
    BR_GTZ = 3'd3,
    BR_LTZ = 3'd4,
    BR_GEZ = 3'd5,
    BR_NV6 = 3'd6,
    BR_NV7 = 3'd7
  } br_mode_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'd0,
    EXT_SIGN = 2'd1,
    EXT_LUI  = 2'd2,
    EXT_NONE = 2'd3
  } ext_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC8 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  localparam int JMP_ALIGN = 2;
  localparam int SEXT_MAX  = 128;

  // Sign-extends a 16-bit immediate; callers size-cast the result down to XLEN.
  function automatic logic [SEXT_MAX-1:0] sext16(input logic [15:0] imm, input int xlen);
    logic [SEXT_MAX-1:0] v;
    v = {{(SEXT_MAX-16){imm[15]}}, imm};
    for (int i = 16; i < SEXT_MAX; i++) begin
      if (i >= xlen) v[i] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/stage_id_pipe_if.sv
// Decode-stage bundle: IF/ID inputs, WB write-back port, forwarding sources and the ID/EX outputs.
// slave is the stage_id_pipe view; master is the driver (surrounding pipeline or bench) view.
interface stage_id_pipe_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFWD = 6,
  localparam int RAW = $clog2(NREG),
  localparam int SW  = $clog2(NFWD + 1)
);
  logic                 id_valid;
  logic [31:0]          instr_id;
  logic [XLEN-1:0]      pc4_id;
  logic [1:0]           pc_src;
  logic [2:0]           br_mode;
  logic [1:0]           ext_op;
  logic [SW-1:0]        rd1_sel;
  logic [SW-1:0]        rd2_sel;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 reg_write_wb;
  logic [RAW-1:0]       a3_wb;
  logic [1:0]           mem_to_reg_wb;
  logic [XLEN-1:0]      alu_res_wb;
  logic [XLEN-1:0]      mem_rd_wb;
  logic [XLEN-1:0]      pc4_wb;
  logic [XLEN-1:0]      ext_imm_wb;
  logic                 ex_ready;
  logic                 flush;
  logic [XLEN-1:0]      npc;
  logic                 npc_taken;
  logic                 id_stall;
  logic                 ex_valid;
  logic [XLEN-1:0]      ex_rd1;
  logic [XLEN-1:0]      ex_rd2;
  logic [XLEN-1:0]      ex_imm;
  logic [31:0]          ex_instr;
  logic [XLEN-1:0]      ex_pc4;

  modport slave (
    input  id_valid, instr_id, pc4_id, pc_src, br_mode, ext_op, rd1_sel, rd2_sel, fwd_data,
           reg_write_wb, a3_wb, mem_to_reg_wb, alu_res_wb, mem_rd_wb, pc4_wb, ext_imm_wb,
           ex_ready, flush,
    output npc, npc_taken, id_stall, ex_valid, ex_rd1, ex_rd2, ex_imm, ex_instr, ex_pc4
  );

  modport master (
    output id_valid, instr_id, pc4_id, pc_src, br_mode, ext_op, rd1_sel, rd2_sel, fwd_data,
           reg_write_wb, a3_wb, mem_to_reg_wb, alu_res_wb, mem_rd_wb, pc4_wb, ext_imm_wb,
           ex_ready, flush,
    input  npc, npc_taken, id_stall, ex_valid, ex_rd1, ex_rd2, ex_imm, ex_instr, ex_pc4
  );
endinterface

// File: rtl/stage_id_pipe_gpr_file.sv
// General-purpose register file: two combinational read ports, one write port, r0 hard-wired to zero.
// ID_WB_BYPASS_EN makes a read of the register being written this cycle return the new data.
module gpr_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RAW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RAW-1:0]  i_ra1,
  input  logic [RAW-1:0]  i_ra2,
  input  logic            i_we,
  input  logic [RAW-1:0]  i_wa,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_regs [NREG];

  // NOTE: the array is reset because software relies on every GPR reading zero after reset;
  // that forces flops instead of a RAM macro, acceptable for a 32-entry file.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [RAW-1:0] addr);
    if (addr == '0) return '0;
`ifdef ID_WB_BYPASS_EN
    if (i_we && (addr == i_wa)) return i_wd;
`endif
    return r_regs[addr];
  endfunction

  assign o_rd1 = read_port(i_ra1);
  assign o_rd2 = read_port(i_ra2);

endmodule

// File: rtl/stage_id_pipe.sv
// MIPS decode stage: GPR read/write-back, operand forwarding, branch compare, next-PC, immediate
// extension and a valid/ready ID/EX register. Optional macro ID_WB_BYPASS_EN enables GPR write-through.
module stage_id_pipe
  import stage_id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFWD = 6,
  localparam int RAW = $clog2(NREG),
  localparam int SW  = $clog2(NFWD + 1)
) (
  input logic            clk,
  input logic            rst,
  stage_id_pipe_if.slave bus
);

  logic [XLEN-1:0] w_wb_data, w_gpr_rd1, w_gpr_rd2, w_rd1_fwd, w_rd2_fwd;
  logic [XLEN-1:0] w_imm_sext, w_imm_ext, w_pc_seq, w_npc;
  logic [15:0]     w_imm16;
  logic            w_cond, w_taken, w_load;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_rd1, r_ex_rd2, r_ex_imm, r_ex_pc4;
  logic [31:0]     r_ex_instr;

  always_comb begin
    w_wb_data = bus.alu_res_wb;
    case (wb_sel_e'(bus.mem_to_reg_wb))
      WB_ALU:  w_wb_data = bus.alu_res_wb;
      WB_MEM:  w_wb_data = bus.mem_rd_wb;
      WB_PC8:  w_wb_data = bus.pc4_wb + XLEN'(4);
      WB_IMM:  w_wb_data = bus.ext_imm_wb;
      default: w_wb_data = bus.alu_res_wb;
    endcase
  end

  gpr_file #(.XLEN(XLEN), .NREG(NREG)) u_gpr (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (bus.instr_id[21 +: RAW]),
    .i_ra2 (bus.instr_id[16 +: RAW]),
    .i_we  (bus.reg_write_wb),
    .i_wa  (bus.a3_wb),
    .i_wd  (w_wb_data),
    .o_rd1 (w_gpr_rd1),
    .o_rd2 (w_gpr_rd2)
  );

  // Select 0 is the GPR, 1..NFWD an external slot; any other code yields zero.
  function automatic logic [XLEN-1:0] fwd_pick(input logic [SW-1:0] sel,
                                               input logic [XLEN-1:0] gpr,
                                               input logic [NFWD*XLEN-1:0] slots);
    logic [XLEN-1:0] v;
    v = '0;
    if (sel == '0) v = gpr;
    for (int k = 1; k <= NFWD; k++) begin
      if (sel == SW'(k)) v = slots[(k-1)*XLEN +: XLEN];
    end
    return v;
  endfunction

  assign w_rd1_fwd = fwd_pick(bus.rd1_sel, w_gpr_rd1, bus.fwd_data);
  assign w_rd2_fwd = fwd_pick(bus.rd2_sel, w_gpr_rd2, bus.fwd_data);

  always_comb begin
    w_cond = 1'b0;
    case (br_mode_e'(bus.br_mode))
      BR_EQ:   w_cond = (w_rd1_fwd == w_rd2_fwd);
      BR_NE:   w_cond = (w_rd1_fwd != w_rd2_fwd);
      BR_LEZ:  w_cond = w_rd1_fwd[XLEN-1] || (w_rd1_fwd == '0);
      BR_GTZ:  w_cond = !w_rd1_fwd[XLEN-1] && (w_rd1_fwd != '0);
      BR_LTZ:  w_cond = w_rd1_fwd[XLEN-1];
      BR_GEZ:  w_cond = !w_rd1_fwd[XLEN-1];
      default: w_cond = 1'b0;
    endcase
  end

  assign w_imm16    = bus.instr_id[15:0];
  assign w_imm_sext = XLEN'(sext16(w_imm16, XLEN));

  always_comb begin
    w_imm_ext = '0;
    case (ext_op_e'(bus.ext_op))
      EXT_ZERO: w_imm_ext = XLEN'(w_imm16);
      EXT_SIGN: w_imm_ext = w_imm_sext;
      EXT_LUI:  w_imm_ext = XLEN'({w_imm16, 16'h0000});
      default:  w_imm_ext = '0;
    endcase
  end

  assign w_pc_seq = bus.pc4_id + XLEN'(4);

  always_comb begin
    w_npc   = w_pc_seq;
    w_taken = 1'b0;
    case (pc_src_e'(bus.pc_src))
      PC_SEQ: w_npc = w_pc_seq;
      PC_BR: begin
        w_npc   = w_cond ? (bus.pc4_id + (w_imm_sext << JMP_ALIGN)) : w_pc_seq;
        w_taken = w_cond;
      end
      PC_JMP: begin
        w_npc   = {bus.pc4_id[XLEN-1:28], bus.instr_id[25:0], {JMP_ALIGN{1'b0}}};
        w_taken = 1'b1;
      end
      PC_JR: begin
        w_npc   = w_rd1_fwd;
        w_taken = 1'b1;
      end
      default: w_npc = w_pc_seq;
    endcase
  end

  assign bus.npc       = w_npc;
  assign bus.npc_taken = bus.id_valid && w_taken;

  assign w_load       = bus.id_valid && (!r_ex_valid || bus.ex_ready) && !bus.flush;
  assign bus.id_stall = bus.id_valid && r_ex_valid && !bus.ex_ready;

  // NOTE: pipeline state uses non-blocking assignments so every field samples pre-edge values.
  // flush outranks load; data fields are left untouched when only ex_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_rd1   <= '0;
      r_ex_rd2   <= '0;
      r_ex_imm   <= '0;
      r_ex_instr <= '0;
      r_ex_pc4   <= '0;
    end else if (bus.flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_load) begin
      r_ex_valid <= 1'b1;
      r_ex_rd1   <= w_rd1_fwd;
      r_ex_rd2   <= w_rd2_fwd;
      r_ex_imm   <= w_imm_ext;
      r_ex_instr <= bus.instr_id;
      r_ex_pc4   <= bus.pc4_id;
    end else if (bus.ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign bus.ex_valid = r_ex_valid;
  assign bus.ex_rd1   = r_ex_rd1;
  assign bus.ex_rd2   = r_ex_rd2;
  assign bus.ex_imm   = r_ex_imm;
  assign bus.ex_instr = r_ex_instr;
  assign bus.ex_pc4   = r_ex_pc4;

endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Parametrised decode stage for the MIPS pipeline: register file read/write-back, N-source operand forwarding, multi-mode branch compare, next-PC generation and immediate extension.
- Adds a registered ID/EX output with a valid/ready handshake, stall and flush.
- Sits between the IF/ID register and the EX stage; the write-back port is driven from WB.

Parameters:
XLEN, 32, datapath width; must be >= 32
NREG, 32, number of GPRs; power of two, >= 2
NFWD, 6, number of external forwarding sources
RAW, $clog2(NREG), register address width (derived, do not override)
SW, $clog2(NFWD+1), forward-select width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset
id_valid  in  1  instruction in ID is valid
instr_id  in  32  instruction word
pc4_id  in  XLEN  PC+4 of the ID instruction
pc_src  in  2  0 sequential, 1 conditional branch, 2 j/jal, 3 jr
br_mode  in  3  0 eq, 1 ne, 2 lez, 3 gtz, 4 ltz, 5 gez (6/7 never taken)
ext_op  in  2  0 zero-extend, 1 sign-extend, 2 imm<<16, 3 zero
rd1_sel, rd2_sel  in  SW  0 = GPR; k = fwd_data slot k-1
fwd_data  in  NFWD*XLEN  packed forwarding sources; slot k is bits [k*XLEN +: XLEN]
reg_write_wb  in  1  WB write enable
a3_wb  in  RAW  WB destination register
mem_to_reg_wb  in  2  0 ALU, 1 memory, 2 pc4_wb+4, 3 ext_imm_wb
alu_res_wb, mem_rd_wb, pc4_wb, ext_imm_wb  in  XLEN  WB data sources
ex_ready  in  1  EX accepts the ID/EX contents
flush  in  1  kill the ID/EX contents
npc  out  XLEN  next PC (combinational)
npc_taken  out  1  redirect is active (combinational)
id_stall  out  1  ID must hold; IF/ID must not advance
ex_valid  out  1  ID/EX register holds a valid instruction
ex_rd1, ex_rd2, ex_imm  out  XLEN  registered operands and extended immediate
ex_instr  out  32  registered instruction
ex_pc4  out  XLEN  registered PC+4

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
  - On rst: all GPRs = 0; ex_valid = 0; ex_rd1, ex_rd2, ex_imm, ex_instr and ex_pc4 = 0.
- GPR file:
  - Write on the clk edge when reg_write_wb is high and a3_wb != 0.
  - r0 always reads 0.
  - Reads are combinational on instr_id[25:21] / [20:16], truncated to RAW bits.
  - Same-cycle write and read of the same register returns the old value (see optional feature).
- Write-back mux: selects per mem_to_reg_wb as listed in Ports.
- Forwarding mux: rdN_fwd = GPR value when sel = 0, fwd_data slot sel-1 when 1 <= sel <= NFWD, otherwise 0.
- Branch compare on rd1_fwd / rd2_fwd:
  - eq and ne compare rd1 with rd2.
  - lez, gtz, ltz and gez compare rd1 with 0, signed.
- npc:
  - pc_src 0: pc4_id + 4.
  - pc_src 1: taken gives pc4_id + (sext(imm16) << 2); not taken gives pc4_id + 4.
  - pc_src 2: {pc4_id[XLEN-1:28], instr_id[25:0], 2'b00}.
  - pc_src 3: rd1_fwd.
  - All PC arithmetic is modulo 2^XLEN.
- npc_taken = id_valid && (pc_src 2 or 3, or pc_src 1 with the condition true).
- Extension: 16-bit immediate extended to XLEN per ext_op.
- Handshake:
  - load = id_valid && (!ex_valid || ex_ready) && !flush.
  - id_stall = id_valid && ex_valid && !ex_ready.
  - When load is high, the ID/EX fields capture the forwarded operands, the immediate, instr_id and pc4_id, and ex_valid <= 1 on the next edge.
  - When ex_ready is high and there is no load, ex_valid <= 0.
  - When stalled, all ID/EX fields hold.
- flush has priority over load: ex_valid <= 0 on the next edge; data fields are don't-care.
- rst mid-stall clears ex_valid regardless of the other inputs.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: a GPR read whose address equals a3_wb, with reg_write_wb high and address != 0, returns the same-cycle write-back mux value (write-through).
- Undefined: the read returns the stored value, and the forwarding network must cover that hazard.

Decomposition:
- Package stage_id_pkg holds:
  - pc_src_e, br_mode_e, ext_op_e and wb_sel_e enums.
  - Constant JMP_ALIGN = 2.
  - Function sext16(imm, xlen).
- Sub-module gpr_file (parameters XLEN, NREG; bypass macro handled inside).
- Branch compare, NPC and extension stay in this module.

Test Plan:
1. Reset: rst high 1 cycle, then read r5 with rd1_sel=0 -> ex_rd1 = 0 and ex_valid = 0 after reset.
2. Write-back then read: write r3 = 0x1234 via WB with mem_to_reg_wb=0, then decode rs=3 -> ex_rd1 = 0x1234; a write to r0 = 0xFFFF reads back 0.
3. Forwarding: rd2_sel=4 with slot 3 = 0xDEADBEEF -> ex_rd2 = 0xDEADBEEF; rd2_sel=7 (NFWD=6) -> 0.
4. Branch modes:
   - bgtz, rd1 = 0xFFFFFFFF, pc4 = 0x100, imm = 0x0004 -> npc = 0x104, npc_taken = 0.
   - bgtz, rd1 = 1, same pc4 and imm -> npc = 0x110, npc_taken = 1.
   - beq, imm = 0xFFFF -> npc = 0xFC.
5. Stall/flush:
   - ex_valid = 1 and ex_ready = 0 for 3 cycles -> id_stall = 1 and fields stable.
   - flush together with load -> ex_valid = 0 on the next cycle.
6. Bypass: same-cycle write r7 = 0xA5 and read rs=7 -> 0xA5 with ID_WB_BYPASS_EN, old value 0 without it.
